// File: rtl/rcc_pkg.sv
// rcc_pkg: shared state encoding, default timing constants and counter sizing for rcc_seq
package rcc_pkg;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    localparam int RCC_HOLD    = 10;
    localparam int RCC_STAGGER = 4;
    localparam int RCC_DIV     = 27;

    // The sequence counter stops one past the last release edge, so it must hold total+1.
    function automatic int seq_w(input int hold, input int num_ch, input int stagger);
        return $clog2(hold + (num_ch - 1) * stagger + 2);
    endfunction

endpackage

// File: rtl/rcc_ce_div.sv
// rcc_ce_div: per-channel programmable clock-enable divider gated by the channel release
module rcc_ce_div
    import rcc_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = RCC_DIV
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             ce
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] div_q, cnt, cnt_d, d_cur, d_sel;
    logic             en_q;

    always_comb begin
        d_cur = div_q == '0 ? ONE : div_q;
        d_sel = div_load ? (div_val == '0 ? ONE : div_val) : d_cur;
        cnt_d = (!en_q || clr || div_load || cnt == d_cur - ONE) ? '0 : cnt + ONE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q <= DIV_W'(DEF_DIV);
            cnt   <= '0;
            en_q  <= 1'b0;
            ce    <= 1'b0;
        end else begin
            div_q <= div_load ? div_val : div_q;
            cnt   <= cnt_d;
            en_q  <= en;
            ce    <= en && cnt_d == d_sel - ONE;
        end
    end

endmodule

// File: rtl/rcc_seq.sv
// rcc_seq: staggered active-low channel reset sequencer with per-channel clock-enable ticks
module rcc_seq
    import rcc_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int HOLD_CYCLES    = RCC_HOLD,
    parameter int STAGGER_CYCLES = RCC_STAGGER,
    parameter int DIV_W          = 16,
    parameter int DEF_DIV        = RCC_DIV
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    SW_RST_REQ,
    input  logic [NUM_CH*DIV_W-1:0] DIV_VAL,
    input  logic [NUM_CH-1:0]       DIV_LOAD,
    output logic [NUM_CH-1:0]       RESETn_O,
    output logic [NUM_CH-1:0]       CE_O,
    output logic                    READY,
    output logic [1:0]              STATE_O
);

    localparam int   TOTAL = HOLD_CYCLES + (NUM_CH - 1) * STAGGER_CYCLES;
    localparam int   CW    = seq_w(HOLD_CYCLES, NUM_CH, STAGGER_CYCLES);
    localparam logic SKIP  = (STAGGER_CYCLES == 0) || (NUM_CH == 1);

    logic [CW-1:0]     cnt;
    logic [1:0]        state;
    logic [NUM_CH-1:0] rel, rstn_d;

    always_comb begin
        rel = '0;
        for (int i = 0; i < NUM_CH; i++)
            rel[i] = state != ST_RUN && cnt == CW'(HOLD_CYCLES + i * STAGGER_CYCLES);
        rstn_d = (RESET || SW_RST_REQ) ? '0 : RESETn_O | rel;
    end

    // A software request edge is itself the new E0, so counting resumes one step ahead.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_HOLD;
            cnt   <= '0;
            READY <= 1'b0;
        end else if (SW_RST_REQ) begin
            state <= ST_HOLD;
            cnt   <= CW'(1);
            READY <= 1'b0;
        end else begin
            cnt   <= state != ST_RUN ? cnt + CW'(1) : cnt;
            state <= (state == ST_HOLD && cnt == CW'(HOLD_CYCLES)) ? (SKIP ? ST_RUN : ST_RELEASE)
                   : (state == ST_RELEASE && cnt == CW'(TOTAL)) ? ST_RUN : state;
            READY <= READY | (state != ST_RUN && cnt == CW'(TOTAL));
        end
        RESETn_O <= rstn_d;
    end

    assign STATE_O = state;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rcc_ce_div #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_div (
            .CLK     (CLK),
            .RESET   (RESET),
            .clr     (SW_RST_REQ),
            .en      (rstn_d[c]),
            .div_val (DIV_VAL[c*DIV_W +: DIV_W]),
            .div_load(DIV_LOAD[c]),
            .ce      (CE_O[c])
        );
    end

endmodule

// File: tb/tb_rcc_seq.sv
// tb_rcc_seq: scoreboard bench for rcc_seq with staggered and unstaggered instances
module tb_rcc_seq;

    typedef struct packed {
        logic [3:0] rn;
        logic [3:0] ce;
        logic       rdy;
        logic [1:0] st;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SW_RST_REQ = 1'b0;
    logic [63:0] DIV_VAL = '0;
    logic [3:0]  DIV_LOAD = '0;
    logic [3:0]  rn_a, ce_a, rn_b, ce_b;
    logic        rdy_a, rdy_b;
    logic [1:0]  st_a, st_b;

    exp_t q_a[$], q_b[$];
    int   n_cmp = 0, n_bad = 0;
    int   t = 0, e0 = 0;
    bit   in_rst = 1'b1;
    int   dv[4] = '{27, 27, 27, 27};
    int   ll[4] = '{-1, -1, -1, -1};

    always #5 CLK = ~CLK;

    rcc_seq dut_a (
        .CLK(CLK), .RESET(RESET), .SW_RST_REQ(SW_RST_REQ), .DIV_VAL(DIV_VAL), .DIV_LOAD(DIV_LOAD),
        .RESETn_O(rn_a), .CE_O(ce_a), .READY(rdy_a), .STATE_O(st_a)
    );

    rcc_seq #(.STAGGER_CYCLES(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .SW_RST_REQ(SW_RST_REQ), .DIV_VAL(DIV_VAL), .DIV_LOAD(DIV_LOAD),
        .RESETn_O(rn_b), .CE_O(ce_b), .READY(rdy_b), .STATE_O(st_b)
    );

    // Expected outputs after edge t: release edges from E0, tick phase from max(release, last load).
    function automatic exp_t model(input int s);
        exp_t e = '0;
        int   r, a, d;
        if (in_rst) return e;
        for (int i = 0; i < 4; i++) begin
            r = e0 + 10 + i * s;
            d = dv[i] == 0 ? 1 : dv[i];
            a = r > ll[i] ? r : ll[i];
            e.rn[i] = t >= r;
            e.ce[i] = t >= r && (t - a) % d == d - 1;
        end
        e.rdy = e.rn[3];
        e.st  = e.rn[3] ? 2'd2 : e.rn[0] ? 2'd1 : 2'd0;
        return e;
    endfunction

    task automatic step(input bit rst, input bit sw, input logic [3:0] ld, input logic [63:0] val);
        RESET = rst;
        SW_RST_REQ = sw;
        DIV_LOAD = ld;
        DIV_VAL = val;
        @(posedge CLK);
        #1;
        if (rst) begin
            in_rst = 1'b1;
            for (int i = 0; i < 4; i++) begin
                dv[i] = 27;
                ll[i] = -1;
            end
        end else begin
            if (in_rst || sw) begin
                e0 = t;
                in_rst = 1'b0;
            end
            for (int i = 0; i < 4; i++)
                if (ld[i]) begin
                    dv[i] = int'(val[i*16 +: 16]);
                    ll[i] = t;
                end
        end
        q_a.push_back(model(4));
        q_b.push_back(model(0));
        t++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'b0, 64'b0);
    endtask

    task automatic check(input string nm, input exp_t act, input exp_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got rn=%b ce=%b rdy=%b st=%0d, want rn=%b ce=%b rdy=%b st=%0d",
                     nm, $time, act.rn, act.ce, act.rdy, act.st, exp.rn, exp.ce, exp.rdy, exp.st);
        end
    endtask

    always @(negedge CLK) begin
        if (q_a.size() > 0) check("stagger4", {rn_a, ce_a, rdy_a, st_a}, q_a.pop_front());
        if (q_b.size() > 0) check("stagger0", {rn_b, ce_b, rdy_b, st_b}, q_b.pop_front());
    end

    initial begin
        logic [63:0] v;
        logic [3:0]  ld;
        int          w;
        repeat (5) step(1'b1, 1'b0, 4'b0, 64'b0);
        idle(140);
        step(1'b0, 1'b0, 4'b0010, 64'h0000_0000_0003_0000);
        idle(12);
        step(1'b0, 1'b0, 4'b0010, 64'h0);
        idle(10);
        step(1'b0, 1'b1, 4'b0, 64'b0);
        idle(15);
        step(1'b0, 1'b1, 4'b0, 64'b0);
        idle(40);
        step(1'b0, 1'b0, 4'b0100, 64'h0000_0005_0000_0000);
        idle(20);
        step(1'b1, 1'b0, 4'b0, 64'b0);
        idle(90);
        for (int k = 0; k < 4000; k++) begin
            ld = '0;
            v  = '0;
            for (int i = 0; i < 4; i++) begin
                ld[i] = $urandom_range(0, 39) == 0;
                v[i*16 +: 16] = $urandom_range(0, 9) == 0 ? 16'(27) : 16'($urandom_range(0, 8));
            end
            step($urandom_range(0, 599) == 0, $urandom_range(0, 299) == 0, ld, v);
        end
        w = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && w < 5) begin
            @(negedge CLK);
            #1;
            w++;
        end
        if (q_a.size() > 0 || q_b.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rcc_seq.md
Name: rcc_seq

Overview:
Parametrised synthesizable reset and clock-enable controller, the successor to the fixed single-reset clock/reset generator.
- Takes the board clock (27 MHz nominal) and one synchronous active-high reset.
- Produces NUM_CH staggered active-low channel resets, a READY flag, and one programmable clock-enable tick per channel.
- Sits at the top of the DDS function generator and feeds the phase accumulator, waveform LUT and DAC interface domains.

Parameters:
NUM_CH, 4, number of reset/clock-enable channels (1..8)
HOLD_CYCLES, 10, cycles channel 0 stays in reset after RESET deasserts (>=1)
STAGGER_CYCLES, 4, cycles between successive channel releases (0 = all channels release together)
DIV_W, 16, width of each clock-enable divide value
DEF_DIV, 27, reset value of every divide register (27 MHz -> 1 MHz tick)

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
SW_RST_REQ  in  1  one-cycle pulse; re-runs the reset sequence
DIV_VAL  in  NUM_CH*DIV_W  divide values; channel i uses slice [i*DIV_W +: DIV_W]
DIV_LOAD  in  NUM_CH  per-channel strobe; loads the matching DIV_VAL slice
RESETn_O  out  NUM_CH  per-channel active-low reset
CE_O  out  NUM_CH  per-channel clock-enable tick
READY  out  1  high when all channels are released
STATE_O  out  2  FSM state: 0 HOLD, 1 RELEASE, 2 RUN

Behaviour:
Interface
- One clock, CLK. Reset is synchronous and active-high, on RESET.

Reset (RESET=1 at an edge), regardless of state:
- state=HOLD, sequence counter=0, RESETn_O=0, CE_O=0, READY=0.
- All divide registers=DEF_DIV, all divider counters=0.
- All outputs are registered.

FSM
- HOLD: the counter increments on each edge with RESET=0. Call E0 the first edge at which RESET is sampled low.
  - RESETn_O[0] rises at edge E0+HOLD_CYCLES-1+1, i.e. exactly HOLD_CYCLES edges after E0 (edge E0 counts as edge 0).
  - Then go to RELEASE.
- RELEASE: RESETn_O[i] rises at E0+HOLD_CYCLES+i*STAGGER_CYCLES.
  - READY rises on the same edge as RESETn_O[NUM_CH-1]; state goes to RUN on that edge.
  - With STAGGER_CYCLES=0 or NUM_CH=1, RELEASE is skipped: HOLD goes directly to RUN.
- RUN: remains in RUN until RESET or SW_RST_REQ.
- A released channel never re-asserts except via RESET or SW_RST_REQ.

SW_RST_REQ
- In RUN or RELEASE: on the next edge all RESETn_O=0, CE_O=0, READY=0, counter=0, state=HOLD. Sequencing then restarts with that edge acting as E0.
- In HOLD: the counter restarts at 0.
- Divide registers keep their values; divider counters clear.
- RESET has priority over SW_RST_REQ.

Clock-enable divider (per channel)
- Effective divide D = divide register, with 0 treated as 1.
- The counter is held at 0 while RESETn_O[i]=0.
- If RESETn_O[i] rises at edge R, CE_O[i] is high for one cycle after edges R+D-1, R+2D-1, ...
  - The counter wraps D-1 -> 0.
  - D=1 gives CE_O[i] continuously high from edge R.
- DIV_LOAD[i] at edge L: the divide register takes the new slice, the counter clears, CE_O[i]=0 after L.
  - Exception: if the new D=1, CE_O[i]=1 after L.
  - The next pulse comes after edge L+D-1, then every D cycles.
- DIV_LOAD while the channel is in reset: the register loads and the counter stays 0.
- DIV_LOAD ignored during RESET.
- Counter width is DIV_W; there is no overflow path because D <= 2^DIV_W-1.

Decomposition:
Package rcc_pkg
- 2-bit state encoding (ST_HOLD=0, ST_RELEASE=1, ST_RUN=2).
- Default constants: HOLD 10, STAGGER 4, DEF_DIV 27.
- Helper function computing the sequence-counter width from HOLD_CYCLES+(NUM_CH-1)*STAGGER_CYCLES.

Sub-module rcc_ce_div
- One per channel, generated NUM_CH times.
- Contains the divide register, counter, load and CE_O logic.
- Inputs: CLK, RESET, channel release, sequence clear, DIV_VAL slice, DIV_LOAD.

Top level
- Holds the FSM, sequence counter, RESETn_O, READY and STATE_O.

Test Plan:
1. Defaults; RESET high 5 cycles, then low (E0) -> RESETn_O[0..3] rise at E0+10/14/18/22; READY and STATE_O=2 at E0+22; CE_O all 0 before the respective release.
2. Default DIV 27 after ch0 release at R -> CE_O[0] one-cycle pulses after R+26, R+53, R+80; never two consecutive cycles high.
3. In RUN, DIV_LOAD[1]=1 with slice 3 at L -> CE_O[1] pulses after L+2, L+5, L+8. Then load 0 -> CE_O[1] constantly high; other channels unaffected.
4. SW_RST_REQ during RELEASE after ch1 released -> next edge all RESETn_O=0, READY=0, STATE_O=0. Re-release at +10/+14/+18/+22 from that edge; loaded divide values preserved.
5. RESET pulsed for 1 cycle mid-RUN after DIV_LOAD -> all outputs 0, STATE_O=0; divide registers back to 27, seen via a 27-cycle CE period after re-release.
6. STAGGER_CYCLES=0, NUM_CH=4 -> all RESETn_O and READY rise together at E0+10; STATE_O goes HOLD->RUN directly, never 1.
